// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter
//   Shares one sram-like slave port (towards the AXI bridge) between the
//   inst and data sram-like masters. Each request is arbitrated on its own.
//   The grant is held until addr_ok. A small in-order owner queue steers
//   every data_ok/rdata back to the master that issued the request.
//
//   Build option ARB_RR_EN:
//     defined   -> round-robin arbitration between inst and data
//     undefined -> fixed priority, data beats inst
module sram_req_arbiter #(
    parameter int OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,

    output logic        s_sram_req,
    output logic        s_sram_wr,
    output logic [1:0]  s_sram_size,
    output logic [3:0]  s_sram_wstrb,
    output logic [31:0] s_sram_addr,
    output logic [31:0] s_sram_wdata,
    input  logic [31:0] s_sram_rdata,
    input  logic        s_sram_addr_ok,
    input  logic        s_sram_data_ok,

    output logic        arb_err
);

    localparam int CNT_W = $clog2(OUTSTANDING + 1);

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    // Grant lock: keeps the selected master on the port until addr_ok
    logic   lock_v;
    owner_e lock_id;

    // Owner queue: bit 0 is the head (oldest accepted request)
    logic [OUTSTANDING-1:0] owner_q, owner_q_next;
    logic [CNT_W-1:0]       count, count_next, widx;

    owner_e sel;
    logic   sel_req;
    logic   full, empty;
    logic   accept, push, pop;

`ifdef ARB_RR_EN
    owner_e rr_ptr;
`endif

    assign full   = (count == CNT_W'(OUTSTANDING));
    assign empty  = (count == '0);
    assign accept = s_sram_req & s_sram_addr_ok;
    assign push   = accept;
    assign pop    = s_sram_data_ok & ~empty;

    // Pick the master that owns the address phase this cycle
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        sel = OWN_INST;
        if (lock_v) begin
            sel = lock_id;
        end else begin
`ifdef ARB_RR_EN
            if (inst_sram_req && data_sram_req) begin
                sel = rr_ptr;
            end else if (data_sram_req) begin
                sel = OWN_DATA;
            end
`else
            if (data_sram_req) begin
                sel = OWN_DATA;
            end
`endif
        end
    end

    // Address-phase mux towards the bridge plus per-master addr_ok
    always_comb begin
        s_sram_wr         = 1'b0;
        s_sram_size       = '0;
        s_sram_wstrb      = '0;
        s_sram_addr       = '0;
        s_sram_wdata      = '0;
        inst_sram_addr_ok = 1'b0;
        data_sram_addr_ok = 1'b0;

        sel_req    = (sel == OWN_DATA) ? data_sram_req : inst_sram_req;
        s_sram_req = sel_req & ~full;

        if (s_sram_req) begin
            if (sel == OWN_DATA) begin
                s_sram_wr         = data_sram_wr;
                s_sram_size       = data_sram_size;
                s_sram_wstrb      = data_sram_wstrb;
                s_sram_addr       = data_sram_addr;
                s_sram_wdata      = data_sram_wdata;
                data_sram_addr_ok = s_sram_addr_ok;
            end else begin
                s_sram_wr         = inst_sram_wr;
                s_sram_size       = inst_sram_size;
                s_sram_wstrb      = inst_sram_wstrb;
                s_sram_addr       = inst_sram_addr;
                s_sram_wdata      = inst_sram_wdata;
                inst_sram_addr_ok = s_sram_addr_ok;
            end
        end
    end

    // Response routing: the queue head names the owner of this data_ok
    always_comb begin
        inst_sram_data_ok = pop & (owner_q[0] == OWN_INST);
        data_sram_data_ok = pop & (owner_q[0] == OWN_DATA);
    end

    assign inst_sram_rdata = s_sram_rdata;
    assign data_sram_rdata = s_sram_rdata;

    // Lock register: set on an unaccepted request, cleared on acceptance
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            lock_v  <= 1'b0;
            lock_id <= OWN_INST;
        end else if (accept) begin
            lock_v  <= 1'b0;
        end else if (s_sram_req) begin
            lock_v  <= 1'b1;
            lock_id <= sel;
        end
    end

    // Owner queue next state: shift out on pop, write behind the tail on push
    always_comb begin
        owner_q_next = owner_q;
        widx         = count;
        if (pop) begin
            owner_q_next = owner_q >> 1;
            widx         = count - CNT_W'(1);
        end
        if (push) begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                if (CNT_W'(i) == widx) begin
                    owner_q_next[i] = sel;
                end
            end
        end
        count_next = count + CNT_W'(push) - CNT_W'(pop);
    end

    // Owner queue, occupancy and sticky protocol-error flag
    always_ff @(posedge clk) begin
        // NOTE: the owner queue is only a few flops, so it is cleared on reset
        //       to make the head well defined straight away.
        if (reset) begin
            owner_q <= '0;
            count   <= '0;
            arb_err <= 1'b0;
        end else begin
            owner_q <= owner_q_next;
            count   <= count_next;
            if (s_sram_data_ok && empty) begin
                arb_err <= 1'b1;
            end
        end
    end

`ifdef ARB_RR_EN
    // Round-robin pointer: after each acceptance prefer the other master
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= OWN_INST;
        end else if (accept) begin
            rr_ptr <= (sel == OWN_INST) ? OWN_DATA : OWN_INST;
        end
    end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter: the bench plays both masters
// and the bridge, and keeps a scoreboard of expected response owners.
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;

    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic        data_sram_addr_ok, data_sram_data_ok;

    logic        s_sram_req, s_sram_wr;
    logic [1:0]  s_sram_size;
    logic [3:0]  s_sram_wstrb;
    logic [31:0] s_sram_addr, s_sram_wdata, s_sram_rdata;
    logic        s_sram_addr_ok, s_sram_data_ok;
    logic        arb_err;

    int tests_run    = 0;
    int tests_failed = 0;

    bit exp_owner_q[$];   // 0 = inst, 1 = data
    bit m_ptr = 1'b0;     // model of the preferred master (round-robin build)

    always #5 clk = ~clk;

    sram_req_arbiter #(.OUTSTANDING(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_rdata   (inst_sram_rdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_rdata   (data_sram_rdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .s_sram_req        (s_sram_req),
        .s_sram_wr         (s_sram_wr),
        .s_sram_size       (s_sram_size),
        .s_sram_wstrb      (s_sram_wstrb),
        .s_sram_addr       (s_sram_addr),
        .s_sram_wdata      (s_sram_wdata),
        .s_sram_rdata      (s_sram_rdata),
        .s_sram_addr_ok    (s_sram_addr_ok),
        .s_sram_data_ok    (s_sram_data_ok),
        .arb_err           (arb_err)
    );

    task automatic idle();
        inst_sram_req   = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
        inst_sram_wstrb = 4'h0; inst_sram_addr = '0; inst_sram_wdata = '0;
        data_sram_req   = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2;
        data_sram_wstrb = 4'h0; data_sram_addr = '0; data_sram_wdata = '0;
        s_sram_addr_ok  = 1'b0; s_sram_data_ok = 1'b0; s_sram_rdata = '0;
    endtask

    // Winner when both masters request with no lock
    function automatic bit exp_winner_both();
`ifdef ARB_RR_EN
        return m_ptr;
`else
        return 1'b1;
`endif
    endfunction

    task automatic note_accept(input bit owner);
        exp_owner_q.push_back(owner);
        m_ptr = ~owner;
    endtask

    // Bridge returns n responses back to back; each is checked against the scoreboard
    task automatic drain(input int n);
        bit          exp;
        logic [31:0] rd;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rd = $urandom;
            s_sram_data_ok = 1'b1;
            s_sram_rdata   = rd;
            #1;
            tests_run++;
            if (exp_owner_q.size() == 0) begin
                tests_failed++;
                $display("FAIL drain_underflow: scoreboard empty at response %0d", k);
            end else begin
                exp = exp_owner_q.pop_front();
                if ({inst_sram_data_ok, data_sram_data_ok} !== {~exp, exp}) begin
                    tests_failed++;
                    $display("FAIL drain_route[%0d]: inst/data data_ok got %b%b expected %b%b",
                             k, inst_sram_data_ok, data_sram_data_ok, ~exp, exp);
                end
            end
            tests_run++;
            if (inst_sram_rdata !== rd || data_sram_rdata !== rd) begin
                tests_failed++;
                $display("FAIL drain_rdata[%0d]: got %h/%h expected %h",
                         k, inst_sram_rdata, data_sram_rdata, rd);
            end
        end
        @(negedge clk);
        s_sram_data_ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        s_sram_rdata = 32'h1234_5678;
        #1;
        tests_run++;
        if ({s_sram_req, s_sram_wr, s_sram_size, s_sram_wstrb, s_sram_addr, s_sram_wdata,
             inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok,
             arb_err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: req=%b addr=%h aok=%b%b dok=%b%b err=%b expected all 0",
                     s_sram_req, s_sram_addr, inst_sram_addr_ok, data_sram_addr_ok,
                     inst_sram_data_ok, data_sram_data_ok, arb_err);
        end
        tests_run++;
        if (inst_sram_rdata !== 32'h1234_5678 || data_sram_rdata !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL reset_rdata_pass: got %h/%h expected 12345678",
                     inst_sram_rdata, data_sram_rdata);
        end
    endtask

    task automatic test_single_inst();
        @(negedge clk);
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'hBFC0_0000;
        s_sram_addr_ok = 1'b1;
        #1;
        tests_run++;
        if ({s_sram_req, inst_sram_addr_ok, data_sram_addr_ok} !== 3'b110 ||
            s_sram_addr !== 32'hBFC0_0000) begin
            tests_failed++;
            $display("FAIL single_addr: req/aok=%b%b%b addr=%h expected 110 bfc00000",
                     s_sram_req, inst_sram_addr_ok, data_sram_addr_ok, s_sram_addr);
        end
        note_accept(1'b0);
        @(negedge clk);
        idle();
        @(negedge clk);
        s_sram_data_ok = 1'b1;
        s_sram_rdata   = 32'h3C1D_0000;
        #1;
        tests_run++;
        if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b10 ||
            inst_sram_rdata !== 32'h3C1D_0000) begin
            tests_failed++;
            $display("FAIL single_data: dok=%b%b rdata=%h expected 10 3c1d0000",
                     inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata);
        end
        void'(exp_owner_q.pop_front());
        @(negedge clk);
        idle();
    endtask

    task automatic test_both_req();
        bit w;
        @(negedge clk);
        inst_sram_req  = 1'b1; inst_sram_addr = 32'h0000_1000;
        data_sram_req  = 1'b1; data_sram_addr = 32'h0000_2000;
        s_sram_addr_ok = 1'b1;
        for (int g = 0; g < 4; g++) begin
            #1;
            w = exp_winner_both();
            tests_run++;
            if (s_sram_addr !== (w ? 32'h0000_2000 : 32'h0000_1000) ||
                {inst_sram_addr_ok, data_sram_addr_ok} !== {~w, w}) begin
                tests_failed++;
                $display("FAIL both_grant[%0d]: addr=%h aok=%b%b expected winner %0d",
                         g, s_sram_addr, inst_sram_addr_ok, data_sram_addr_ok, w);
            end
            note_accept(w);
            @(negedge clk);
        end
        #1;
        tests_run++;
        if ({s_sram_req, inst_sram_addr_ok, data_sram_addr_ok} !== 3'b000) begin
            tests_failed++;
            $display("FAIL both_full_block: req/aok=%b%b%b expected 000",
                     s_sram_req, inst_sram_addr_ok, data_sram_addr_ok);
        end
        idle();
        drain(4);
    endtask

    task automatic test_lock();
        @(negedge clk);
        inst_sram_req  = 1'b1; inst_sram_addr = 32'h0000_0100;
        s_sram_addr_ok = 1'b0;
        #1;
        tests_run++;
        if (s_sram_req !== 1'b1 || s_sram_addr !== 32'h0000_0100 || inst_sram_addr_ok !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_start: req=%b addr=%h aok=%b expected 1 00000100 0",
                     s_sram_req, s_sram_addr, inst_sram_addr_ok);
        end
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            data_sram_req  = 1'b1; data_sram_addr = 32'h0000_0200;
            #1;
            tests_run++;
            if (s_sram_addr !== 32'h0000_0100 || {inst_sram_addr_ok, data_sram_addr_ok} !== 2'b00) begin
                tests_failed++;
                $display("FAIL lock_hold[%0d]: addr=%h aok=%b%b expected 00000100 00",
                         c, s_sram_addr, inst_sram_addr_ok, data_sram_addr_ok);
            end
        end
        @(negedge clk);
        s_sram_addr_ok = 1'b1;
        #1;
        tests_run++;
        if (s_sram_addr !== 32'h0000_0100 || {inst_sram_addr_ok, data_sram_addr_ok} !== 2'b10) begin
            tests_failed++;
            $display("FAIL lock_release: addr=%h aok=%b%b expected 00000100 10",
                     s_sram_addr, inst_sram_addr_ok, data_sram_addr_ok);
        end
        note_accept(1'b0);
        @(negedge clk);
        inst_sram_req = 1'b0;
        #1;
        tests_run++;
        if (s_sram_addr !== 32'h0000_0200 || {inst_sram_addr_ok, data_sram_addr_ok} !== 2'b01) begin
            tests_failed++;
            $display("FAIL lock_next: addr=%h aok=%b%b expected 00000200 01",
                     s_sram_addr, inst_sram_addr_ok, data_sram_addr_ok);
        end
        note_accept(1'b1);
        @(negedge clk);
        idle();
        drain(2);
    endtask

    task automatic test_full();
        bit exp;
        @(negedge clk);
        inst_sram_req  = 1'b1; inst_sram_addr = 32'h0000_0300;
        s_sram_addr_ok = 1'b1;
        for (int g = 0; g < 4; g++) begin
            #1;
            tests_run++;
            if (inst_sram_addr_ok !== 1'b1) begin
                tests_failed++;
                $display("FAIL full_fill[%0d]: inst_addr_ok got %b expected 1", g, inst_sram_addr_ok);
            end
            note_accept(1'b0);
            @(negedge clk);
        end
        // Occupancy at the limit: the fifth request must be held off
        #1;
        tests_run++;
        if ({s_sram_req, inst_sram_addr_ok} !== 2'b00) begin
            tests_failed++;
            $display("FAIL full_block: req/aok=%b%b expected 00", s_sram_req, inst_sram_addr_ok);
        end
        s_sram_data_ok = 1'b1;
        s_sram_rdata   = 32'h0000_0001;
        #1;
        exp = exp_owner_q.pop_front();
        tests_run++;
        if ({s_sram_req, inst_sram_data_ok, data_sram_data_ok} !== {1'b0, ~exp, exp}) begin
            tests_failed++;
            $display("FAIL full_pop: req/dok=%b%b%b expected 0%b%b",
                     s_sram_req, inst_sram_data_ok, data_sram_data_ok, ~exp, exp);
        end
        @(negedge clk);
        s_sram_data_ok = 1'b0;
        #1;
        tests_run++;
        if ({s_sram_req, inst_sram_addr_ok} !== 2'b11) begin
            tests_failed++;
            $display("FAIL full_resume: req/aok=%b%b expected 11", s_sram_req, inst_sram_addr_ok);
        end
        note_accept(1'b0);
        // Drop one entry, then push and pop together at occupancy 3
        @(negedge clk);
        inst_sram_req = 1'b0;
        drain(1);
        inst_sram_req  = 1'b1; inst_sram_addr = 32'h0000_0304;
        s_sram_addr_ok = 1'b1;
        s_sram_data_ok = 1'b1;
        #1;
        exp = exp_owner_q.pop_front();
        tests_run++;
        if ({inst_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok} !== {1'b1, ~exp, exp}) begin
            tests_failed++;
            $display("FAIL full_push_pop: aok/dok=%b%b%b expected 1%b%b",
                     inst_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok, ~exp, exp);
        end
        note_accept(1'b0);
        @(negedge clk);
        idle();
        drain(3);
        tests_run++;
        if (dut.count !== '0) begin
            tests_failed++;
            $display("FAIL full_count_end: count got %0d expected 0", dut.count);
        end
    endtask

    task automatic test_order();
        @(negedge clk);
        inst_sram_req  = 1'b1; inst_sram_addr = 32'h0000_0010;
        s_sram_addr_ok = 1'b1;
        #1;
        tests_run++;
        if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b10) begin
            tests_failed++;
            $display("FAIL order_i0: aok=%b%b expected 10", inst_sram_addr_ok, data_sram_addr_ok);
        end
        note_accept(1'b0);
        @(negedge clk);
        inst_sram_req   = 1'b0;
        data_sram_req   = 1'b1; data_sram_wr = 1'b1; data_sram_wstrb = 4'b0011;
        data_sram_size  = 2'd1; data_sram_addr = 32'h0000_0020; data_sram_wdata = 32'hA5A5_A5A5;
        #1;
        tests_run++;
        if ({s_sram_wr, s_sram_size, s_sram_wstrb} !== 7'b1_01_0011 || s_sram_addr !== 32'h0000_0020 ||
            s_sram_wdata !== 32'hA5A5_A5A5 || {inst_sram_addr_ok, data_sram_addr_ok} !== 2'b01) begin
            tests_failed++;
            $display("FAIL order_d_write: wr=%b size=%0d wstrb=%b addr=%h wdata=%h aok=%b%b expected 1 1 0011 00000020 a5a5a5a5 01",
                     s_sram_wr, s_sram_size, s_sram_wstrb, s_sram_addr, s_sram_wdata,
                     inst_sram_addr_ok, data_sram_addr_ok);
        end
        note_accept(1'b1);
        @(negedge clk);
        idle();
        inst_sram_req  = 1'b1; inst_sram_addr = 32'h0000_0030;
        s_sram_addr_ok = 1'b1;
        #1;
        tests_run++;
        if ({inst_sram_addr_ok, data_sram_addr_ok, s_sram_wr} !== 3'b100) begin
            tests_failed++;
            $display("FAIL order_i2: aok=%b%b wr=%b expected 10 0",
                     inst_sram_addr_ok, data_sram_addr_ok, s_sram_wr);
        end
        note_accept(1'b0);
        @(negedge clk);
        idle();
        drain(3);
        tests_run++;
        if (dut.count !== '0) begin
            tests_failed++;
            $display("FAIL order_count_end: count got %0d expected 0", dut.count);
        end
    endtask

    task automatic test_err_and_reset();
        @(negedge clk);
        idle();
        s_sram_data_ok = 1'b1;
        #1;
        tests_run++;
        if ({inst_sram_data_ok, data_sram_data_ok, arb_err} !== 3'b000) begin
            tests_failed++;
            $display("FAIL err_spurious: dok=%b%b err=%b expected 000",
                     inst_sram_data_ok, data_sram_data_ok, arb_err);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            s_sram_data_ok = 1'b0;
            #1;
            tests_run++;
            if (arb_err !== 1'b1) begin
                tests_failed++;
                $display("FAIL err_sticky[%0d]: arb_err got %b expected 1", c, arb_err);
            end
        end
        // Leave a request in flight, then reset mid-operation
        @(negedge clk);
        inst_sram_req  = 1'b1; inst_sram_addr = 32'h0000_0040;
        s_sram_addr_ok = 1'b1;
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_owner_q.delete();
        m_ptr = 1'b0;
        #1;
        tests_run++;
        if (arb_err !== 1'b0 || dut.count !== '0 || s_sram_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_reset: err=%b count=%0d req=%b expected 0 0 0",
                     arb_err, dut.count, s_sram_req);
        end
        s_sram_data_ok = 1'b1;
        #1;
        tests_run++;
        if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin
            tests_failed++;
            $display("FAIL err_queue_cleared: dok=%b%b expected 00",
                     inst_sram_data_ok, data_sram_data_ok);
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        test_reset();
        test_single_inst();
        test_both_req();
        test_lock();
        test_full();
        test_order();
        test_err_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
